// File: rtl/pc_seq_pkg.sv
// Shared branch-control encodings for the program-counter sequencer.
package pc_seq_pkg;

    localparam int unsigned BRA_W = 3;

    localparam logic [BRA_W-1:0] BRA_NEXT  = 3'd0;
    localparam logic [BRA_W-1:0] BRA_IRQ   = 3'd1;
    localparam logic [BRA_W-1:0] BRA_JMPI  = 3'd2;
    localparam logic [BRA_W-1:0] BRA_JMPR  = 3'd3;
    localparam logic [BRA_W-1:0] BRA_CALLI = 3'd4;
    localparam logic [BRA_W-1:0] BRA_CALLR = 3'd5;
    localparam logic [BRA_W-1:0] BRA_RET   = 3'd6;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry.
// Top of stack is kept in its own register so it is a clean flop output.
module pc_ras #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] top_o,
    output logic [AW:0]      depth_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    sp_q, sp_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0] top_q, top_d;
    logic [AW-1:0]    below_top;

    // sp_q points at the next free slot, so the entry under the top sits two back.
    assign below_top = sp_q - AW'(2);
    assign full_o    = (cnt_q == FULL_CNT);
    assign empty_o   = (cnt_q == '0);
    assign top_o     = top_q;
    assign depth_o   = cnt_q;

    always_comb begin
        sp_d  = sp_q;
        cnt_d = cnt_q;
        top_d = top_q;
        if (push_i) begin
            sp_d  = sp_q + AW'(1);
            cnt_d = full_o ? cnt_q : cnt_q + (AW+1)'(1);
            top_d = data_i;
        end else if (pop_i) begin
            sp_d  = sp_q - AW'(1);
            cnt_d = cnt_q - (AW+1)'(1);
            top_d = (cnt_q > (AW+1)'(1)) ? mem_q[below_top] : '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sp_q  <= '0;
            cnt_q <= '0;
            top_q <= '0;
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
            top_q <= top_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[sp_q] <= data_i;
    end

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer with call/return stack and sticky stack-error flags.
// Define PC_SEQ_IRQ_PUSH_EN to have IRQ push the interrupted pc onto the stack.
module pc_seq
    import pc_seq_pkg::*;
#(
    parameter int unsigned     PCW       = 9,
    parameter logic [PCW-1:0]  RESET_PC  = PCW'(1),
    parameter logic [PCW-1:0]  IRQ_VEC   = PCW'(0),
    parameter int unsigned     RAS_DEPTH = 4,
    parameter int unsigned     RAS_AW    = 2
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             gate_ni,
    input  logic [BRA_W-1:0] bra_ctl_i,
    input  logic [PCW-1:0]   immed_i,
    input  logic [PCW-1:0]   reg_i,
    input  logic             clr_i,
    output logic [PCW-1:0]   pc_o,
    output logic [PCW-1:0]   ret_o,
    output logic [RAS_AW:0]  depth_o,
    output logic             ovf_o,
    output logic             unf_o
);

    logic [PCW-1:0] pc_q, pc_d, pc_next;
    logic           ovf_q, ovf_d, unf_q, unf_d;
    logic           push, pop, unf_set, ras_full, ras_empty;
    logic [PCW-1:0] push_data, ras_top;

    assign pc_next = pc_q + PCW'(1);

    always_comb begin
        pc_d      = pc_q;
        push      = 1'b0;
        pop       = 1'b0;
        push_data = pc_next;
        unf_set   = 1'b0;
        if (gate_ni) begin
            case (bra_ctl_i)
                BRA_IRQ: begin
                    pc_d = IRQ_VEC;
`ifdef PC_SEQ_IRQ_PUSH_EN
                    push      = 1'b1;
                    push_data = pc_q;
`endif
                end
                BRA_JMPI:  pc_d = immed_i;
                BRA_JMPR:  pc_d = reg_i;
                BRA_CALLI: begin
                    pc_d = immed_i;
                    push = 1'b1;
                end
                BRA_CALLR: begin
                    pc_d = reg_i;
                    push = 1'b1;
                end
                BRA_RET: begin
                    if (ras_empty) begin
                        pc_d    = pc_next;
                        unf_set = 1'b1;
                    end else begin
                        pc_d = ras_top;
                        pop  = 1'b1;
                    end
                end
                default: pc_d = pc_next;
            endcase
        end
    end

    // Set takes priority over clear; clear is honoured even while stalled.
    always_comb begin
        ovf_d = (push && ras_full) ? 1'b1 : (clr_i ? 1'b0 : ovf_q);
        unf_d = unf_set            ? 1'b1 : (clr_i ? 1'b0 : unf_q);
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            pc_q  <= RESET_PC;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    pc_ras #(
        .WIDTH (PCW),
        .DEPTH (RAS_DEPTH),
        .AW    (RAS_AW)
    ) u_ras (
        .clk_i   (clock_i),
        .rst_i   (reset_i),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (push_data),
        .top_o   (ras_top),
        .depth_o (depth_o),
        .full_o  (ras_full),
        .empty_o (ras_empty)
    );

    assign pc_o  = pc_q;
    assign ret_o = ras_top;
    assign ovf_o = ovf_q;
    assign unf_o = unf_q;

endmodule

// File: tb/tb_pc_seq.sv
// Directed scoreboard bench for pc_seq (default parameters, either IRQ-push build).
module tb_pc_seq;
    import pc_seq_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       gate  = 1'b0;
    logic [2:0] bra   = BRA_NEXT;
    logic [8:0] immed = '0;
    logic [8:0] regv  = '0;
    logic       clr   = 1'b0;
    logic [8:0] pc, ret;
    logic [2:0] depth;
    logic       ovf, unf;

    pc_seq #(
        .PCW       (9),
        .RESET_PC  (9'h001),
        .IRQ_VEC   (9'h000),
        .RAS_DEPTH (4),
        .RAS_AW    (2)
    ) dut (
        .clock_i   (clock),
        .reset_i   (reset),
        .gate_ni   (gate),
        .bra_ctl_i (bra),
        .immed_i   (immed),
        .reg_i     (regv),
        .clr_i     (clr),
        .pc_o      (pc),
        .ret_o     (ret),
        .depth_o   (depth),
        .ovf_o     (ovf),
        .unf_o     (unf)
    );

    always #5 clock = ~clock;

    typedef struct {
        string      name;
        logic [8:0] pc;
        logic [8:0] ret;
        logic [2:0] depth;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t sb[$];
    event chk_ev;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Monitor: one expectation is consumed per clock edge (or async-check event).
    initial begin
        exp_t e;
        forever begin
            @(posedge clock or chk_ev);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (pc !== e.pc || ret !== e.ret || depth !== e.depth ||
                    ovf !== e.ovf || unf !== e.unf) begin
                    n_bad++;
                    $display("FAIL %s: got pc=%h ret=%h depth=%0d ovf=%b unf=%b, want pc=%h ret=%h depth=%0d ovf=%b unf=%b",
                             e.name, pc, ret, depth, ovf, unf, e.pc, e.ret, e.depth, e.ovf, e.unf);
                end
            end
        end
    end

    task automatic expect_push(input string nm, input logic [8:0] epc, input logic [8:0] eret,
                               input logic [2:0] ed, input logic eo, input logic eu);
        exp_t e;
        e.name = nm; e.pc = epc; e.ret = eret; e.depth = ed; e.ovf = eo; e.unf = eu;
        sb.push_back(e);
    endtask

    task automatic step(input logic [2:0] b, input logic [8:0] imm, input logic [8:0] rg,
                        input logic g, input logic c, input string nm,
                        input logic [8:0] epc, input logic [8:0] eret,
                        input logic [2:0] ed, input logic eo, input logic eu);
        @(negedge clock);
        bra = b; immed = imm; regv = rg; gate = g; clr = c;
        expect_push(nm, epc, eret, ed, eo, eu);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clock);
        expect_push("reset", 9'h001, 9'h000, 3'd0, 1'b0, 1'b0);
        -> chk_ev;
        @(negedge clock);
        reset = 1'b0;

        step(BRA_NEXT, 9'h000, 9'h000, 1, 0, "next1", 9'h002, 9'h000, 0, 0, 0);
        step(BRA_NEXT, 9'h000, 9'h000, 1, 0, "next2", 9'h003, 9'h000, 0, 0, 0);
        step(BRA_NEXT, 9'h000, 9'h000, 1, 0, "next3", 9'h004, 9'h000, 0, 0, 0);

        step(BRA_JMPI, 9'h1FF, 9'h000, 1, 0, "jmpi_max", 9'h1FF, 9'h000, 0, 0, 0);
        step(BRA_NEXT, 9'h000, 9'h000, 1, 0, "wrap",     9'h000, 9'h000, 0, 0, 0);
        step(BRA_JMPI, 9'h055, 9'h000, 0, 0, "stall_jmp",  9'h000, 9'h000, 0, 0, 0);
        step(BRA_CALLI, 9'h066, 9'h000, 0, 0, "stall_call", 9'h000, 9'h000, 0, 0, 0);

        step(BRA_JMPI,  9'h010, 9'h000, 1, 0, "jmpi_010", 9'h010, 9'h000, 0, 0, 0);
        step(BRA_CALLI, 9'h100, 9'h000, 1, 0, "calli",    9'h100, 9'h011, 1, 0, 0);
        step(BRA_CALLR, 9'h000, 9'h080, 1, 0, "callr",    9'h080, 9'h101, 2, 0, 0);
        step(BRA_RET,   9'h000, 9'h000, 1, 0, "ret1",     9'h101, 9'h011, 1, 0, 0);
        step(BRA_RET,   9'h000, 9'h000, 1, 0, "ret2",     9'h011, 9'h000, 0, 0, 0);

        step(BRA_CALLI, 9'h020, 9'h000, 1, 0, "ov_call1", 9'h020, 9'h012, 1, 0, 0);
        step(BRA_CALLI, 9'h030, 9'h000, 1, 0, "ov_call2", 9'h030, 9'h021, 2, 0, 0);
        step(BRA_CALLI, 9'h040, 9'h000, 1, 0, "ov_call3", 9'h040, 9'h031, 3, 0, 0);
        step(BRA_CALLI, 9'h060, 9'h000, 1, 0, "ov_call4", 9'h060, 9'h041, 4, 0, 0);
        step(BRA_CALLI, 9'h070, 9'h000, 1, 0, "ov_call5", 9'h070, 9'h061, 4, 1, 0);
        step(BRA_RET,   9'h000, 9'h000, 1, 0, "ov_ret1",  9'h061, 9'h041, 3, 1, 0);
        step(BRA_RET,   9'h000, 9'h000, 1, 0, "ov_ret2",  9'h041, 9'h031, 2, 1, 0);
        step(BRA_RET,   9'h000, 9'h000, 1, 0, "ov_ret3",  9'h031, 9'h021, 1, 1, 0);
        step(BRA_RET,   9'h000, 9'h000, 1, 0, "ov_ret4",  9'h021, 9'h000, 0, 1, 0);
        step(BRA_NEXT,  9'h000, 9'h000, 1, 1, "ovf_clr",  9'h022, 9'h000, 0, 0, 0);

        step(BRA_JMPI, 9'h020, 9'h000, 1, 0, "jmpi_020",  9'h020, 9'h000, 0, 0, 0);
        step(BRA_RET,  9'h000, 9'h000, 1, 0, "unf_set",   9'h021, 9'h000, 0, 0, 1);
        step(BRA_RET,  9'h000, 9'h000, 1, 1, "unf_setwin", 9'h022, 9'h000, 0, 0, 1);
        step(BRA_NEXT, 9'h000, 9'h000, 1, 1, "unf_clr",   9'h023, 9'h000, 0, 0, 0);
        step(BRA_RET,  9'h000, 9'h000, 1, 0, "unf_again", 9'h024, 9'h000, 0, 0, 1);
        step(BRA_RET,  9'h000, 9'h000, 0, 1, "stall_clr", 9'h024, 9'h000, 0, 0, 0);

        step(BRA_JMPI, 9'h050, 9'h000, 1, 0, "jmpi_050", 9'h050, 9'h000, 0, 0, 0);
`ifdef PC_SEQ_IRQ_PUSH_EN
        step(BRA_IRQ,  9'h000, 9'h000, 1, 0, "irq",      9'h000, 9'h050, 1, 0, 0);
        step(BRA_RET,  9'h000, 9'h000, 1, 0, "irq_ret",  9'h050, 9'h000, 0, 0, 0);
`else
        step(BRA_IRQ,  9'h000, 9'h000, 1, 0, "irq",      9'h000, 9'h000, 0, 0, 0);
        step(BRA_RET,  9'h000, 9'h000, 1, 0, "irq_ret",  9'h001, 9'h000, 0, 0, 1);
        step(BRA_NEXT, 9'h000, 9'h000, 1, 1, "irq_clr",  9'h002, 9'h000, 0, 0, 0);
`endif

        step(BRA_JMPI,  9'h0A0, 9'h000, 1, 0, "jmpi_0a0", 9'h0A0, 9'h000, 0, 0, 0);
        step(BRA_CALLI, 9'h100, 9'h000, 1, 0, "rc_call1", 9'h100, 9'h0A1, 1, 0, 0);
        step(BRA_CALLI, 9'h140, 9'h000, 1, 0, "rc_call2", 9'h140, 9'h101, 2, 0, 0);

        // Reset mid-cycle, checked before the next rising edge.
        @(negedge clock);
        gate = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        expect_push("async_reset", 9'h001, 9'h000, 0, 0, 0);
        -> chk_ev;
        @(negedge clock);
        reset = 1'b0;
        step(BRA_RET, 9'h000, 9'h000, 1, 0, "post_rst_unf", 9'h002, 9'h000, 0, 0, 1);

        @(negedge clock);
        gate = 1'b0;
        bra  = BRA_NEXT;
        clr  = 1'b0;
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clock);
        if (sb.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
